// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared types and constants for the multi-mode clock core:
//            operating modes, edit-field selection, field moduli and the
//            bit offsets of each field inside the packed cur_time word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2
  } field_t;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int SEC_OFS  = 0;
  localparam int MIN_OFS  = 8;
  localparam int HOUR_OFS = 16;

  // Edit-field rotation used by key_next: HOUR -> MIN -> SEC -> HOUR.
  function automatic field_t next_field(input field_t f);
    case (f)
      HOUR:    return MIN;
      MIN:     return SEC;
      default: return HOUR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-N up counter with synchronous clear. Used for the time
//            fields, the alarm fields and the one-second prescaler.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            inc            - advance by one (wraps MODULUS-1 -> 0)
//            load_zero      - force the count to zero (beats inc)
//            value [W-1:0]  - current count
//            wrap           - inc while at MODULUS-1 (combinational carry)
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load_zero,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_value;

  assign value = r_value;
  assign wrap  = inc & (r_value == c_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (load_zero) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= (r_value == c_max) ? '0 : r_value + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_core.sv
`default_nettype none
// ============================================================================
// Module   : clock_core
// Purpose  : Time-keeping and mode controller: prescaled h:m:s counter,
//            alarm registers, RUN/SET_TIME/SET_ALARM mode machine driven by
//            three debounced key pulses, and the alarm ringing timer.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            key_mode/key_next/key_inc   - single-cycle key pulses
//            cur_time [23:0]             - {hour, minute, second} in binary
//            hour/minute/second_flash    - selected edit field (SET modes)
//            alarming                    - alarm ringing
//            alarm_en                    - alarm armed
// Revision : 1.0 - initial release
// ============================================================================
module clock_core
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int ALARM_SECS    = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        key_inc,
  output logic [23:0] cur_time,
  output logic        second_flash,
  output logic        minute_flash,
  output logic        hour_flash,
  output logic        alarming,
  output logic        alarm_en
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);
  localparam int CNT_W = $clog2(ALARM_SECS + 1);

  mode_t            r_mode;
  field_t           r_field;
  logic             r_alarm_en;
  logic             r_alarming;
  logic [CNT_W-1:0] r_ring_cnt;

  logic             w_tick;
  logic [PRE_W-1:0] w_pre_unused;
  logic [7:0]       w_sec, w_min, w_hour;
  logic [7:0]       w_asec, w_amin, w_ahour;
  logic             w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [2:0]       w_alarm_wrap_unused;
  logic [7:0]       w_nsec, w_nmin, w_nhour;
  logic             w_trigger, w_key_ok, w_any_key;
  logic             w_do_mode, w_do_next, w_do_inc;
  logic             w_edit_time, w_edit_alarm;

  // --------------------------------------------------------------------------
  // Prescaler: frozen at zero in SET_TIME so the first second after an edit
  // is a full second; its carry is the one-second tick.
  // --------------------------------------------------------------------------
  mod_counter #(.MODULUS(TICKS_PER_SEC), .WIDTH(PRE_W)) u_pre (
    .clk(clk), .rst_n(rst_n),
    .inc(r_mode != SET_TIME), .load_zero(r_mode == SET_TIME),
    .value(w_pre_unused), .wrap(w_tick)
  );

  // --------------------------------------------------------------------------
  // Key decode. Keys are ignored while ringing or when the alarm fires in
  // this very cycle; the ringing logic uses the raw pulse to cancel.
  // --------------------------------------------------------------------------
  assign w_any_key    = key_mode | key_next | key_inc;
  assign w_key_ok     = ~r_alarming & ~w_trigger;
  assign w_do_mode    = key_mode & w_key_ok;
  assign w_do_next    = key_next & ~key_mode & w_key_ok;
  assign w_do_inc     = key_inc & ~key_mode & ~key_next & w_key_ok;
  assign w_edit_time  = w_do_inc & (r_mode == SET_TIME);
  assign w_edit_alarm = w_do_inc & (r_mode == SET_ALARM);

  // --------------------------------------------------------------------------
  // Time counters. Carries only come from ticks, so edits never ripple into
  // the next field (ticks never happen in SET_TIME anyway).
  // --------------------------------------------------------------------------
  mod_counter #(.MODULUS(SEC_MOD)) u_sec (
    .clk(clk), .rst_n(rst_n),
    .inc(w_tick | (w_edit_time & (r_field == SEC))), .load_zero(1'b0),
    .value(w_sec), .wrap(w_sec_wrap)
  );
  mod_counter #(.MODULUS(MIN_MOD)) u_min (
    .clk(clk), .rst_n(rst_n),
    .inc((w_tick & w_sec_wrap) | (w_edit_time & (r_field == MIN))), .load_zero(1'b0),
    .value(w_min), .wrap(w_min_wrap)
  );
  mod_counter #(.MODULUS(HOUR_MOD)) u_hour (
    .clk(clk), .rst_n(rst_n),
    .inc((w_tick & w_sec_wrap & w_min_wrap) | (w_edit_time & (r_field == HOUR))),
    .load_zero(1'b0),
    .value(w_hour), .wrap(w_hour_wrap)
  );

  // Alarm fields: edited only, each wraps on its own.
  mod_counter #(.MODULUS(SEC_MOD)) u_asec (
    .clk(clk), .rst_n(rst_n),
    .inc(w_edit_alarm & (r_field == SEC)), .load_zero(1'b0),
    .value(w_asec), .wrap(w_alarm_wrap_unused[0])
  );
  mod_counter #(.MODULUS(MIN_MOD)) u_amin (
    .clk(clk), .rst_n(rst_n),
    .inc(w_edit_alarm & (r_field == MIN)), .load_zero(1'b0),
    .value(w_amin), .wrap(w_alarm_wrap_unused[1])
  );
  mod_counter #(.MODULUS(HOUR_MOD)) u_ahour (
    .clk(clk), .rst_n(rst_n),
    .inc(w_edit_alarm & (r_field == HOUR)), .load_zero(1'b0),
    .value(w_ahour), .wrap(w_alarm_wrap_unused[2])
  );

  // --------------------------------------------------------------------------
  // Time as it will be after this tick; only meaningful when w_tick is high,
  // which is the only time it is compared against the alarm.
  // --------------------------------------------------------------------------
  assign w_nsec  = w_sec_wrap ? 8'd0 : w_sec + 8'd1;
  assign w_nmin  = w_sec_wrap ? (w_min_wrap ? 8'd0 : w_min + 8'd1) : w_min;
  assign w_nhour = (w_sec_wrap & w_min_wrap) ? (w_hour_wrap ? 8'd0 : w_hour + 8'd1)
                                             : w_hour;

  assign w_trigger = w_tick & r_alarm_en &
                     ({w_nhour, w_nmin, w_nsec} == {w_ahour, w_amin, w_asec});

  // --------------------------------------------------------------------------
  // Mode / field machine and alarm enable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= RUN;
      r_field    <= HOUR;
      r_alarm_en <= 1'b0;
    end else if (w_do_mode) begin
      case (r_mode)
        RUN: begin
          r_mode  <= SET_TIME;
          r_field <= HOUR;
        end
        SET_TIME: begin
          r_mode  <= SET_ALARM;
          r_field <= HOUR;
        end
        default: r_mode <= RUN;
      endcase
    end else if (w_do_next) begin
      if (r_mode != RUN) r_field <= next_field(r_field);
    end else if (w_do_inc && r_mode == RUN) begin
      r_alarm_en <= ~r_alarm_en;
    end
  end

  // --------------------------------------------------------------------------
  // Ringing timer: counts remaining seconds, ends on the tick that brings it
  // to zero or on any key pulse. A fresh trigger always wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarming <= 1'b0;
      r_ring_cnt <= '0;
    end else if (w_trigger) begin
      r_alarming <= 1'b1;
      r_ring_cnt <= CNT_W'(ALARM_SECS);
    end else if (r_alarming) begin
      if (w_any_key) begin
        r_alarming <= 1'b0;
      end else if (w_tick) begin
        r_ring_cnt <= r_ring_cnt - CNT_W'(1);
        if (r_ring_cnt == CNT_W'(1)) r_alarming <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded straight from flop outputs, no further logic depth.
  // --------------------------------------------------------------------------
  always_comb begin
    cur_time = '0;
    if (r_mode == SET_ALARM) begin
      cur_time[HOUR_OFS +: 8] = w_ahour;
      cur_time[MIN_OFS  +: 8] = w_amin;
      cur_time[SEC_OFS  +: 8] = w_asec;
    end else begin
      cur_time[HOUR_OFS +: 8] = w_hour;
      cur_time[MIN_OFS  +: 8] = w_min;
      cur_time[SEC_OFS  +: 8] = w_sec;
    end
  end

  assign hour_flash   = (r_mode != RUN) && (r_field == HOUR);
  assign minute_flash = (r_mode != RUN) && (r_field == MIN);
  assign second_flash = (r_mode != RUN) && (r_field == SEC);
  assign alarming     = r_alarming;
  assign alarm_en     = r_alarm_en;

endmodule
`default_nettype wire

// File: tb/tb_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_core
// Purpose  : Self-checking bench for clock_core. A driver applies key pulses,
//            steps a seconds-of-day reference model and queues the expected
//            outputs; a monitor pops and compares after every clock edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_core;

  localparam int TPS = 4;
  localparam int AS  = 3;
  localparam int DAY = 86400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0;
  logic [23:0] cur_time;
  logic        second_flash, minute_flash, hour_flash, alarming, alarm_en;

  always #5 clk = ~clk;

  clock_core #(.TICKS_PER_SEC(TPS), .ALARM_SECS(AS)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
    .cur_time(cur_time),
    .second_flash(second_flash), .minute_flash(minute_flash), .hour_flash(hour_flash),
    .alarming(alarming), .alarm_en(alarm_en)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time and alarm as seconds of the day.
  // mode 0=RUN 1=SET_TIME 2=SET_ALARM, field 0=hour 1=min 2=sec.
  int m_time, m_alarm, m_pre, m_mode, m_field, m_en, m_ring, m_rem;

  logic [28:0] q[$];

  function automatic logic [23:0] fmt(input int s);
    logic [7:0] h, m, x;
    h = 8'(s / 3600);
    m = 8'((s / 60) % 60);
    x = 8'(s % 60);
    return {h, m, x};
  endfunction

  function automatic int bump(input int s, input int f);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    if (f == 0) h = (h + 1) % 24;
    else if (f == 1) m = (m + 1) % 60;
    else x = (x + 1) % 60;
    return h * 3600 + m * 60 + x;
  endfunction

  function automatic logic [28:0] expect_now();
    logic [23:0] t;
    logic hf, mf, sf;
    t  = (m_mode == 2) ? fmt(m_alarm) : fmt(m_time);
    hf = (m_mode != 0) && (m_field == 0);
    mf = (m_mode != 0) && (m_field == 1);
    sf = (m_mode != 0) && (m_field == 2);
    return {t, hf, mf, sf, 1'(m_ring), 1'(m_en)};
  endfunction

  task automatic model_reset();
    m_time = 0; m_alarm = 0; m_pre = 0; m_mode = 0; m_field = 0;
    m_en = 0; m_ring = 0; m_rem = 0;
  endtask

  task automatic model_step(input logic km, input logic kn, input logic ki);
    logic tick, trig, ok;
    int nt;
    tick = (m_mode != 1) && (m_pre == TPS - 1);
    nt   = tick ? (m_time + 1) % DAY : m_time;
    trig = tick && (m_en != 0) && (nt == m_alarm);
    ok   = (m_ring == 0) && !trig;
    m_pre  = (m_mode == 1) ? 0 : (m_pre + 1) % TPS;
    m_time = nt;
    if (trig) begin
      m_ring = 1; m_rem = AS;
    end else if (m_ring != 0 && (km || kn || ki)) begin
      m_ring = 0;
    end else if (m_ring != 0 && tick) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_ring = 0;
    end
    if (ok) begin
      if (km) begin
        m_mode = (m_mode + 1) % 3;
        if (m_mode != 0) m_field = 0;
      end else if (kn) begin
        if (m_mode != 0) m_field = (m_field + 1) % 3;
      end else if (ki) begin
        if (m_mode == 0) m_en = 1 - m_en;
        else if (m_mode == 1) m_time = bump(m_time, m_field);
        else m_alarm = bump(m_alarm, m_field);
      end
    end
  endtask

  // Monitor: one expected output word per clock edge.
  always @(posedge clk) begin
    logic [28:0] e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {cur_time, hour_flash, minute_flash, second_flash, alarming, alarm_en};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle @%0t: got time=%06h hf/mf/sf/al/en=%05b, expected time=%06h %05b",
                 $time, a[28:5], a[4:0], e[28:5], e[4:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive keys at negedge, predict, return just after the edge.
  task automatic cycle(input logic km, input logic kn, input logic ki);
    @(negedge clk);
    key_mode = km; key_next = kn; key_inc = ki;
    model_step(km, kn, ki);
    q.push_back(expect_now());
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset asserted between edges, checked immediately.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
    model_reset();
    #1;
    check("reset outputs",
          {3'b0, cur_time, hour_flash, minute_flash, second_flash, alarming, alarm_en}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0);
    q.push_back(expect_now());
    @(posedge clk);
    #2;
  endtask

  // From reset: time 00:00:00, alarm 00:00:02, back in RUN with alarm armed.
  task automatic setup_alarm();
    int h, m, s;
    cycle(1, 0, 0);
    h = m_time / 3600; m = (m_time / 60) % 60; s = m_time % 60;
    repeat ((24 - h) % 24) cycle(0, 0, 1);
    cycle(0, 1, 0);
    repeat ((60 - m) % 60) cycle(0, 0, 1);
    cycle(0, 1, 0);
    repeat ((60 - s) % 60) cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    repeat ((62 - (m_alarm % 60)) % 60) cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
  endtask

  task automatic wait_ring(input int target, input int budget);
    int k;
    k = 0;
    while (m_ring != target && k < budget) begin
      cycle(0, 0, 0);
      k++;
    end
    check("alarming level", {31'b0, alarming}, 32'(target));
  endtask

  initial begin
    int h, m, s;
    model_reset();

    // 240 cycles at 4 ticks/s is one minute.
    do_reset();
    repeat (239) cycle(0, 0, 0);
    check("one minute", {8'b0, cur_time}, 32'h000100);
    check("run flashes", {29'b0, hour_flash, minute_flash, second_flash}, 32'h0);

    // Preload 23:59:59 and let it roll over.
    cycle(1, 0, 0);
    h = m_time / 3600; m = (m_time / 60) % 60; s = m_time % 60;
    repeat ((23 - h + 24) % 24) cycle(0, 0, 1);
    cycle(0, 1, 0);
    repeat ((59 - m + 60) % 60) cycle(0, 0, 1);
    cycle(0, 1, 0);
    repeat ((59 - s + 60) % 60) cycle(0, 0, 1);
    check("preload 23:59:59", {8'b0, cur_time}, 32'h173B3B);
    check("sec flash", {31'b0, second_flash}, 32'h1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    check("midnight wrap", {8'b0, cur_time}, 32'h000000);

    // Field edits wrap independently; time frozen in SET_TIME.
    cycle(1, 0, 0);
    check("hour flash", {31'b0, hour_flash}, 32'h1);
    repeat (25) cycle(0, 0, 1);
    check("hour wrap edit", {24'b0, cur_time[23:16]}, 32'h1);
    cycle(0, 1, 0);
    check("minute flash", {31'b0, minute_flash}, 32'h1);
    repeat (60) cycle(0, 0, 1);
    repeat (100) cycle(0, 0, 0);
    check("frozen edit", {8'b0, cur_time}, 32'h010000);

    // Alarm rings for ALARM_SECS ticks.
    do_reset();
    setup_alarm();
    wait_ring(1, 40);
    check("trigger time", {8'b0, cur_time}, 32'h000002);
    wait_ring(0, 40);
    check("ring end time", {8'b0, cur_time}, 32'h000005);
    check("enable kept", {31'b0, alarm_en}, 32'h1);

    // Key cancels ringing and is consumed.
    do_reset();
    setup_alarm();
    wait_ring(1, 40);
    cycle(1, 0, 0);
    check("cancel", {31'b0, alarming}, 32'h0);
    check("still RUN", {29'b0, hour_flash, minute_flash, second_flash}, 32'h0);

    // Reset in the middle of ringing.
    cycle(0, 0, 1);
    do_reset();
    setup_alarm();
    wait_ring(1, 40);
    do_reset();

    // key_mode beats key_inc in the same cycle.
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    check("mode priority flash", {31'b0, hour_flash}, 32'h1);
    check("alarm untouched", {8'b0, cur_time}, 32'h000000);
    cycle(1, 0, 0);
    check("hour single inc", {24'b0, cur_time[23:16]}, 32'h1);

    // Reset in the middle of an edit.
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    do_reset();

    // Random keys, with a nearby alarm so rings occur.
    setup_alarm();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 9) == 0);
      end
    end

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
